// File: rtl/pcie_tx_arb_pkg.sv
// Shared encodings, FSM states and the credit check for the PCIe TX VC arbiter.
package pcie_tx_arb_pkg;

  // TLP type encodings carried on usr_type; 2'b11 is reserved and never granted.
  localparam logic [1:0] TLP_P   = 2'b00;
  localparam logic [1:0] TLP_NP  = 2'b01;
  localparam logic [1:0] TLP_CPL = 2'b10;

  // Bit positions that flag an infinite credit pool.
  localparam int HCRED_INF_BIT = 8;
  localparam int DCRED_INF_BIT = 12;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARB  = 3'd1,
    ST_REQ  = 3'd2,
    ST_XFER = 3'd3,
    ST_GAP  = 3'd4
  } arb_state_e;

  // True when the core advertises at least one header credit and enough data
  // credit for a packet of the given type; infinite pools pass unconditionally.
  function automatic logic credit_ok(
    input logic [1:0]  tlp_type,
    input logic [11:0] dcred,
    input logic [8:0]  ca_ph,
    input logic [8:0]  ca_nph,
    input logic [8:0]  ca_cplh,
    input logic [12:0] ca_pd,
    input logic [12:0] ca_npd,
    input logic [12:0] ca_cpld
  );
    logic [8:0]  ca_h;
    logic [12:0] ca_d;
    logic        type_ok;
    logic        h_ok;
    logic        d_ok;
    ca_h    = 9'd0;
    ca_d    = 13'd0;
    type_ok = 1'b1;
    case (tlp_type)
      TLP_P:   begin ca_h = ca_ph;   ca_d = ca_pd;   end
      TLP_NP:  begin ca_h = ca_nph;  ca_d = ca_npd;  end
      TLP_CPL: begin ca_h = ca_cplh; ca_d = ca_cpld; end
      default: type_ok = 1'b0;
    endcase
    h_ok = ca_h[HCRED_INF_BIT] | (ca_h[7:0] != 8'd0);
    d_ok = ca_d[DCRED_INF_BIT] | (ca_d[11:0] >= dcred);
    return type_ok & h_ok & d_ok;
  endfunction

endpackage

// File: rtl/pcie_rr_arb.sv
// Round-robin picker: first eligible channel at or after ptr_i, wrapping.
module pcie_rr_arb #(
  parameter int NUM_VC = 4,
  parameter int PW     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic [NUM_VC-1:0] elig_i,
  input  logic [PW-1:0]     ptr_i,
  output logic [NUM_VC-1:0] pick_o,
  output logic              valid_o
);

  logic [PW-1:0] idx;
  logic          hit;

  // Walk the channels in priority order from the pointer; the first hit wins.
  always_comb begin
    pick_o  = '0;
    valid_o = 1'b0;
    idx     = '0;
    hit     = 1'b0;
    for (int k = 0; k < NUM_VC; k++) begin
      idx         = PW'((int'(ptr_i) + k) % NUM_VC);
      hit         = ~valid_o & elig_i[idx];
      pick_o[idx] = hit;
      valid_o     = valid_o | hit;
    end
  end

endmodule

// File: rtl/pcie_tx_vc_arb.sv
// Credit-aware round-robin arbiter multiplexing NUM_VC user TLP sources onto
// the core's single transmit port.
module pcie_tx_vc_arb
  import pcie_tx_arb_pkg::*;
#(
  parameter int NUM_VC  = 4,
  parameter int DATA_W  = 16,
  parameter int DCRED_W = 8
) (
  input  logic                      sys_clk_125,
  input  logic                      rst,
  input  logic [NUM_VC-1:0]         usr_req,
  input  logic [2*NUM_VC-1:0]       usr_type,
  input  logic [DCRED_W*NUM_VC-1:0] usr_dcred,
  input  logic [DATA_W*NUM_VC-1:0]  usr_data,
  input  logic [NUM_VC-1:0]         usr_st,
  input  logic [NUM_VC-1:0]         usr_end,
  input  logic [NUM_VC-1:0]         usr_nlfy,
  output logic [NUM_VC-1:0]         usr_gnt,
  output logic [NUM_VC-1:0]         usr_rdy,
  input  logic                      dl_up,
  input  logic                      tx_rdy,
  input  logic [8:0]                tx_ca_ph,
  input  logic [8:0]                tx_ca_nph,
  input  logic [8:0]                tx_ca_cplh,
  input  logic [12:0]               tx_ca_pd,
  input  logic [12:0]               tx_ca_npd,
  input  logic [12:0]               tx_ca_cpld,
  input  logic                      tx_ca_p_recheck,
  input  logic                      tx_ca_cpl_recheck,
  output logic                      tx_req,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_st,
  output logic                      tx_end,
  output logic                      tx_nlfy
);

  localparam int PW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

  arb_state_e        state_q, state_d;
  logic [NUM_VC-1:0] gnt_q, gnt_d;
  logic [PW-1:0]     gidx_q, gidx_d;
  logic [1:0]        gtype_q, gtype_d;
  logic [11:0]       gdcred_q, gdcred_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              recheck_q, recheck_d;

  logic [NUM_VC-1:0] elig_s;
  logic [NUM_VC-1:0] pick_s;
  logic              pick_valid_s;
  logic [PW-1:0]     pick_idx_s;
  logic [1:0]        pick_type_s;
  logic [11:0]       pick_dcred_s;
  logic              recheck_hit_s;
  logic              gnt_cred_ok_s;
  logic [PW-1:0]     rr_next_s;

  // Per-channel eligibility: pending request whose type has enough credit now.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      elig_s[i] = usr_req[i] & credit_ok(usr_type[2*i +: 2],
                                         12'(usr_dcred[DCRED_W*i +: DCRED_W]),
                                         tx_ca_ph, tx_ca_nph, tx_ca_cplh,
                                         tx_ca_pd, tx_ca_npd, tx_ca_cpld);
    end
  end

  pcie_rr_arb #(
    .NUM_VC (NUM_VC),
    .PW     (PW)
  ) u_rr (
    .elig_i  (elig_s),
    .ptr_i   (rr_ptr_q),
    .pick_o  (pick_s),
    .valid_o (pick_valid_s)
  );

  // Decode the one-hot pick into an index and capture that channel's type/credit ask.
  always_comb begin
    pick_idx_s   = '0;
    pick_type_s  = TLP_P;
    pick_dcred_s = 12'd0;
    for (int i = 0; i < NUM_VC; i++) begin
      pick_idx_s   = pick_s[i] ? PW'(i) : pick_idx_s;
      pick_type_s  = pick_s[i] ? usr_type[2*i +: 2] : pick_type_s;
      pick_dcred_s = pick_s[i] ? 12'(usr_dcred[DCRED_W*i +: DCRED_W]) : pick_dcred_s;
    end
  end

  // Non-posted shares the posted recheck strobe; completions have their own.
  assign recheck_hit_s = (gtype_q == TLP_CPL) ? tx_ca_cpl_recheck : tx_ca_p_recheck;
  assign gnt_cred_ok_s = credit_ok(gtype_q, gdcred_q, tx_ca_ph, tx_ca_nph, tx_ca_cplh,
                                   tx_ca_pd, tx_ca_npd, tx_ca_cpld);
  assign rr_next_s     = (gidx_q == PW'(NUM_VC - 1)) ? '0 : gidx_q + PW'(1);

  // Next-state logic: arbitration, core handshake, transfer and link-down abort.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gidx_d    = gidx_q;
    gtype_d   = gtype_q;
    gdcred_d  = gdcred_q;
    rr_ptr_d  = rr_ptr_q;
    recheck_d = 1'b0;
    if (!dl_up) begin
      state_d = ST_IDLE;
      gnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_ARB;
        ST_ARB: begin
          if (pick_valid_s) begin
            state_d  = ST_REQ;
            gnt_d    = pick_s;
            gidx_d   = pick_idx_s;
            gtype_d  = pick_type_s;
            gdcred_d = pick_dcred_s;
          end else begin
            state_d = ST_ARB;
          end
        end
        ST_REQ: begin
          if (recheck_q && !gnt_cred_ok_s) begin
            state_d = ST_ARB;
            gnt_d   = '0;
          end else if (tx_rdy) begin
            state_d = ST_XFER;
          end else begin
            recheck_d = recheck_hit_s;
          end
        end
        ST_XFER: begin
          if (usr_end[gidx_q]) begin
            state_d  = ST_GAP;
            gnt_d    = '0;
            rr_ptr_d = rr_next_s;
          end else begin
            state_d = ST_XFER;
          end
        end
        ST_GAP: state_d = ST_ARB;
        default: begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      endcase
    end
  end

  // State and grant registers; reset clears everything including the RR pointer.
  always_ff @(posedge sys_clk_125 or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      gidx_q    <= '0;
      gtype_q   <= TLP_P;
      gdcred_q  <= 12'd0;
      rr_ptr_q  <= '0;
      recheck_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gidx_q    <= gidx_d;
      gtype_q   <= gtype_d;
      gdcred_q  <= gdcred_d;
      rr_ptr_q  <= rr_ptr_d;
      recheck_q <= recheck_d;
    end
  end

  // Core-side outputs; the data path is a zero-latency mux of the granted channel.
  always_comb begin
    usr_gnt = gnt_q;
    usr_rdy = '0;
    tx_req  = (state_q == ST_REQ);
    tx_data = '0;
    tx_st   = 1'b0;
    tx_end  = 1'b0;
    tx_nlfy = 1'b0;
    if (state_q == ST_XFER) begin
      usr_rdy = gnt_q;
      for (int i = 0; i < NUM_VC; i++) begin
        tx_data = tx_data | (usr_data[DATA_W*i +: DATA_W] & {DATA_W{PW'(i) == gidx_q}});
        tx_st   = tx_st   | (usr_st[i]   & (PW'(i) == gidx_q));
        tx_end  = tx_end  | (usr_end[i]  & (PW'(i) == gidx_q));
        tx_nlfy = tx_nlfy | (usr_nlfy[i] & (PW'(i) == gidx_q));
      end
    end else begin
      usr_rdy = '0;
    end
  end

endmodule

// File: tb/tb_pcie_tx_vc_arb.sv
// Directed + randomized bench for pcie_tx_vc_arb with a rule-level grant model.
module tb_pcie_tx_vc_arb;

  localparam int NV = 4;
  localparam int DW = 16;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NV-1:0]   usr_req;
  logic [2*NV-1:0] usr_type;
  logic [CW*NV-1:0] usr_dcred;
  logic [DW*NV-1:0] usr_data;
  logic [NV-1:0]   usr_st, usr_end, usr_nlfy;
  logic [NV-1:0]   usr_gnt, usr_rdy;
  logic            dl_up, tx_rdy;
  logic [8:0]      tx_ca_ph, tx_ca_nph, tx_ca_cplh;
  logic [12:0]     tx_ca_pd, tx_ca_npd, tx_ca_cpld;
  logic            tx_ca_p_recheck, tx_ca_cpl_recheck;
  logic            tx_req;
  logic [DW-1:0]   tx_data;
  logic            tx_st, tx_end, tx_nlfy;

  int checks   = 0;
  int failures = 0;
  int m_ptr    = 0;

  always #5 clk = ~clk;

  pcie_tx_vc_arb #(.NUM_VC(NV), .DATA_W(DW), .DCRED_W(CW)) dut (
    .sys_clk_125(clk), .rst(rst),
    .usr_req(usr_req), .usr_type(usr_type), .usr_dcred(usr_dcred), .usr_data(usr_data),
    .usr_st(usr_st), .usr_end(usr_end), .usr_nlfy(usr_nlfy),
    .usr_gnt(usr_gnt), .usr_rdy(usr_rdy),
    .dl_up(dl_up), .tx_rdy(tx_rdy),
    .tx_ca_ph(tx_ca_ph), .tx_ca_nph(tx_ca_nph), .tx_ca_cplh(tx_ca_cplh),
    .tx_ca_pd(tx_ca_pd), .tx_ca_npd(tx_ca_npd), .tx_ca_cpld(tx_ca_cpld),
    .tx_ca_p_recheck(tx_ca_p_recheck), .tx_ca_cpl_recheck(tx_ca_cpl_recheck),
    .tx_req(tx_req), .tx_data(tx_data), .tx_st(tx_st), .tx_end(tx_end), .tx_nlfy(tx_nlfy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_gnt"},  64'(usr_gnt), 64'd0);
    chk({tag, "_rdy"},  64'(usr_rdy), 64'd0);
    chk({tag, "_req"},  64'(tx_req),  64'd0);
    chk({tag, "_data"}, 64'(tx_data), 64'd0);
    chk({tag, "_st"},   64'(tx_st),   64'd0);
    chk({tag, "_end"},  64'(tx_end),  64'd0);
    chk({tag, "_nlfy"}, 64'(tx_nlfy), 64'd0);
  endtask

  // Eligibility straight from the rules: pending, legal type, >=1 header
  // credit, enough data credit (>=256 / >=4096 encodes an unlimited pool).
  function automatic bit m_elig(input int c);
    int t, h, d, need;
    t    = int'(usr_type[2*c +: 2]);
    need = int'(usr_dcred[CW*c +: CW]);
    h    = 0;
    d    = 0;
    if (usr_req[c] !== 1'b1 || t == 3) return 1'b0;
    if (t == 0)      begin h = int'(tx_ca_ph);   d = int'(tx_ca_pd);   end
    else if (t == 1) begin h = int'(tx_ca_nph);  d = int'(tx_ca_npd);  end
    else             begin h = int'(tx_ca_cplh); d = int'(tx_ca_cpld); end
    return ((h >= 256) || (h % 256 >= 1)) && ((d >= 4096) || (d % 4096 >= need));
  endfunction

  function automatic int model_pick(input int ptr);
    for (int k = 0; k < NV; k++) begin
      if (m_elig((ptr + k) % NV)) return (ptr + k) % NV;
    end
    return -1;
  endfunction

  task automatic set_inf();
    tx_ca_ph = 9'h100; tx_ca_nph = 9'h100; tx_ca_cplh = 9'h100;
    tx_ca_pd = 13'h1000; tx_ca_npd = 13'h1000; tx_ca_cpld = 13'h1000;
  endtask

  task automatic rand_legal_types();
    for (int c = 0; c < NV; c++) begin
      usr_type[2*c +: 2]   = 2'($urandom_range(0, 2));
      usr_dcred[CW*c +: CW] = 8'($urandom_range(0, 20));
    end
  endtask

  task automatic randomize_all();
    usr_req = 4'($urandom_range(0, 15));
    for (int c = 0; c < NV; c++) begin
      usr_type[2*c +: 2]    = 2'($urandom_range(0, 3));
      usr_dcred[CW*c +: CW] = 8'($urandom_range(0, 15));
    end
    tx_ca_ph   = ($urandom_range(0, 4) == 4) ? (9'h100 | 9'($urandom_range(0, 3))) : 9'($urandom_range(0, 3));
    tx_ca_nph  = ($urandom_range(0, 4) == 4) ? (9'h100 | 9'($urandom_range(0, 3))) : 9'($urandom_range(0, 3));
    tx_ca_cplh = ($urandom_range(0, 4) == 4) ? (9'h100 | 9'($urandom_range(0, 3))) : 9'($urandom_range(0, 3));
    tx_ca_pd   = ($urandom_range(0, 5) == 5) ? 13'h1000 : 13'($urandom_range(0, 20));
    tx_ca_npd  = ($urandom_range(0, 5) == 5) ? 13'h1000 : 13'($urandom_range(0, 20));
    tx_ca_cpld = ($urandom_range(0, 5) == 5) ? 13'h1000 : 13'($urandom_range(0, 20));
  endtask

  // One packet: wait for grant, handshake, nb beats. drop_at / rst_at abort
  // the packet at that beat index by dropping dl_up or pulsing reset.
  task automatic run_packet(input int nb, input int rdy_wait, input int exp_wait,
                            input int drop_at, input int rst_at, output int obs_ch);
    int cyc, exp_ch;
    logic [NV-1:0] exp_oh;
    bit aborted;
    cyc     = 0;
    aborted = 1'b0;
    exp_ch  = model_pick(m_ptr);
    if (exp_ch < 0) exp_ch = 0;
    exp_oh  = NV'(1 << exp_ch);
    while (usr_gnt === '0 && cyc < 20) begin
      tick();
      cyc++;
    end
    if (exp_wait >= 0) chk("req_spacing", 64'(cyc), 64'(exp_wait));
    obs_ch = -1;
    for (int k = 0; k < NV; k++) if (usr_gnt[k] === 1'b1) obs_ch = k;
    chk("grant", 64'(usr_gnt), 64'(exp_oh));
    chk("req_hi", 64'(tx_req), 64'd1);
    chk("rdy_lo", 64'(usr_rdy), 64'd0);
    repeat (rdy_wait) begin
      tick();
      chk("req_hold", 64'(tx_req), 64'd1);
      chk("gnt_hold", 64'(usr_gnt), 64'(exp_oh));
    end
    tx_rdy = 1'b1;
    tick();
    tx_rdy = 1'b0;
    chk("req_drop", 64'(tx_req), 64'd0);
    chk("rdy_hi", 64'(usr_rdy), 64'(exp_oh));
    for (int b = 0; b < nb; b++) begin
      usr_data = {$urandom, $urandom};
      usr_st   = 4'($urandom);
      usr_end  = 4'($urandom);
      usr_nlfy = 4'($urandom);
      usr_st[exp_ch]   = (b == 0);
      usr_end[exp_ch]  = (b == nb - 1);
      usr_nlfy[exp_ch] = (b == nb - 1) ? 1'($urandom) : 1'b0;
      #1;
      if (b == rst_at) begin
        rst = 1'b1;
        #1;
        chk_quiet("rst_async");
        tick();
        rst     = 1'b0;
        m_ptr   = 0;
        aborted = 1'b1;
        break;
      end
      chk("beat_data", 64'(tx_data), 64'(usr_data[DW*exp_ch +: DW]));
      chk("beat_st",   64'(tx_st),   64'(b == 0));
      chk("beat_end",  64'(tx_end),  64'(b == nb - 1));
      chk("beat_nlfy", 64'(tx_nlfy), 64'(usr_nlfy[exp_ch]));
      chk("beat_rdy",  64'(usr_rdy), 64'(exp_oh));
      if (b == drop_at) begin
        dl_up = 1'b0;
        tick();
        chk_quiet("dlup_drop");
        aborted = 1'b1;
        break;
      end
      tick();
    end
    if (!aborted) begin
      m_ptr = (exp_ch + 1) % NV;
      chk_quiet("gap");
      tick();
      chk("arb_req_lo", 64'(tx_req), 64'd0);
    end
  endtask

  initial begin
    int ch;
    int order[5];
    bit stalled;
    order = '{0, 1, 2, 3, 0};
    rst = 1'b1; dl_up = 1'b0; tx_rdy = 1'b0;
    tx_ca_p_recheck = 1'b0; tx_ca_cpl_recheck = 1'b0;
    usr_req = '0; usr_type = '0; usr_dcred = '0; usr_data = '0;
    usr_st = '0; usr_end = '0; usr_nlfy = '0;
    tx_ca_ph = '0; tx_ca_nph = '0; tx_ca_cplh = '0;
    tx_ca_pd = '0; tx_ca_npd = '0; tx_ca_cpld = '0;
    tick();
    tick();
    chk_quiet("reset");
    rst = 1'b0;
    set_inf();
    usr_req = 4'hF;
    rand_legal_types();
    tick();
    tick();
    chk_quiet("link_down");

    // Rotation with all channels requesting and unlimited credit.
    dl_up = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_packet(2 + (i % 3), i % 2, (i == 0) ? 2 : 1, -1, -1, ch);
      chk("rr_order", 64'(ch), 64'(order[i]));
    end

    // Credit-blocked posted channel 1 is skipped in favour of completion channel 2.
    usr_req = 4'b0110;
    usr_type[3:2] = 2'b00; usr_dcred[15:8]  = 8'd8;
    usr_type[5:4] = 2'b10; usr_dcred[23:16] = 8'd2;
    tx_ca_ph = 9'd3; tx_ca_pd = 13'd4; tx_ca_cplh = 9'd2; tx_ca_cpld = 13'd2;
    run_packet(2, 0, 1, -1, -1, ch);
    chk("credit_skip", 64'(ch), 64'd2);
    tx_ca_pd = 13'd8;
    run_packet(2, 1, 1, -1, -1, ch);
    chk("credit_unblock", 64'(ch), 64'd1);

    // Recheck in REQ with posted header credit gone revokes the grant.
    usr_req = 4'b1000;
    usr_type[7:6] = 2'b00; usr_dcred[31:24] = 8'd3;
    tx_ca_ph = 9'd2; tx_ca_pd = 13'h1000;
    tick();
    chk("rechk_gnt", 64'(usr_gnt), 64'h8);
    chk("rechk_req", 64'(tx_req), 64'd1);
    tx_ca_ph = 9'd0;
    tx_ca_p_recheck = 1'b1;
    tick();
    tx_ca_p_recheck = 1'b0;
    tick();
    chk("rechk_req_lo", 64'(tx_req), 64'd0);
    chk("rechk_gnt_lo", 64'(usr_gnt), 64'd0);
    tick();
    chk("rechk_blocked", 64'(usr_gnt), 64'd0);
    tx_ca_ph = 9'd2;
    run_packet(3, 0, 1, -1, -1, ch);
    chk("rechk_regrant", 64'(ch), 64'd3);

    // Link drop on the third beat of a six-beat packet, then regrant same channel.
    set_inf();
    usr_req = 4'hF;
    rand_legal_types();
    run_packet(6, 1, 1, 2, -1, ch);
    chk("drop_ch", 64'(ch), 64'd0);
    dl_up = 1'b1;
    run_packet(2, 0, 2, -1, -1, ch);
    chk("drop_regrant", 64'(ch), 64'd0);

    // Reset mid-transfer clears the pointer: lowest requester wins afterwards.
    usr_req = 4'b0111;
    run_packet(5, 0, 1, -1, 1, ch);
    chk("rst_pre_ch", 64'(ch), 64'd1);
    usr_req = 4'b0101;
    run_packet(2, 0, 2, -1, -1, ch);
    chk("rst_lowest", 64'(ch), 64'd0);

    // Reserved type on channel 1 is never granted; the rest keep rotating.
    usr_req = 4'hF;
    usr_type[3:2] = 2'b11;
    for (int i = 0; i < 4; i++) begin
      run_packet(1 + i, 0, 1, -1, -1, ch);
      chk("rsvd_skip", 64'(ch == 1), 64'd0);
    end

    // Random traffic against the model.
    for (int it = 0; it < 24; it++) begin
      randomize_all();
      stalled = (model_pick(m_ptr) < 0);
      if (stalled) begin
        repeat (3) begin
          tick();
          chk("stall_gnt", 64'(usr_gnt), 64'd0);
          chk("stall_req", 64'(tx_req), 64'd0);
        end
        set_inf();
        usr_req[0] = 1'b1;
        usr_type[1:0] = 2'b01;
      end
      run_packet($urandom_range(1, 4), $urandom_range(0, 2), 1, -1, -1, ch);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
